// File: rtl/onchip_mem_pkg.sv
// rtl/onchip_mem_pkg.sv - shared state type, default sizes and burst address helpers
// ONCHIP_BURST_WRAP_EN adds the wrap-window mask helper.
package onchip_mem_pkg;

  localparam int DEF_ADDR_W    = 14;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_BE_W      = DEF_DATA_W / 8;
  localparam int DEF_BURST_W   = 4;
  localparam int DEF_MEM_WORDS = 10240;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  // An all-ones mask gives a plain linear increment.
  function automatic logic [DEF_ADDR_W-1:0] next_addr(
    input logic [DEF_ADDR_W-1:0] addr,
    input logic [DEF_ADDR_W-1:0] window_mask
  );
    logic [DEF_ADDR_W-1:0] w_inc;
    w_inc = addr + 1'b1;
    return (addr & ~window_mask) | (w_inc & window_mask);
  endfunction

`ifdef ONCHIP_BURST_WRAP_EN
  // Mask is P-1 where P is the next power of two >= burstcount.
  function automatic logic [DEF_ADDR_W-1:0] window_mask(
    input logic [DEF_BURST_W-1:0] bc
  );
    logic [DEF_BURST_W-1:0] w_x;
    logic [DEF_BURST_W-1:0] w_m;
    w_x = (bc == '0) ? '0 : bc - 1'b1;
    w_m = '0;
    for (int i = 0; i < DEF_BURST_W; i++) begin
      w_m = w_m | (w_x >> i);
    end
    return DEF_ADDR_W'(w_m);
  endfunction
`endif

endpackage

// File: rtl/onchip_mem_rd_return.sv
// rtl/onchip_mem_rd_return.sv - two-stage read return pipeline aligned to the RAM's one-cycle latency
// Out-of-range beats return valid with zero data.
module onchip_mem_rd_return
  import onchip_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_issue,
  input  logic              i_oor,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid
);

  logic              r_v1;
  logic              r_z1;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // Stage 1 tracks the beat while the RAM is reading it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_z1 <= 1'b0;
    end else begin
      r_v1 <= i_issue;
      r_z1 <= i_oor;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= r_v1;
      r_data  <= (r_v1 && !r_z1) ? i_rdata : '0;
    end
  end

  assign o_rdata  = r_data;
  assign o_rvalid = r_valid;

endmodule

// File: rtl/onchip_mem_burst_adapter.sv
// rtl/onchip_mem_burst_adapter.sv - Avalon-MM burst slave splitting bursts into single RAM word accesses
// ONCHIP_BURST_WRAP_EN switches bursts to wrap inside an aligned power-of-two window.
module onchip_mem_burst_adapter
  import onchip_mem_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BE_W      = DEF_BE_W,
  parameter int BURST_W   = DEF_BURST_W,
  parameter int MEM_WORDS = DEF_MEM_WORDS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  s_address,
  input  logic [BURST_W-1:0] s_burstcount,
  input  logic               s_read,
  input  logic               s_write,
  input  logic [DATA_W-1:0]  s_writedata,
  input  logic [BE_W-1:0]    s_byteenable,
  output logic               s_waitrequest,
  output logic [DATA_W-1:0]  s_readdata,
  output logic               s_readdatavalid,
  output logic               err_sticky,
  input  logic               err_clr,
  output logic [ADDR_W-1:0]  m_address,
  output logic [BE_W-1:0]    m_byteenable,
  output logic               m_chipselect,
  output logic               m_write,
  output logic [DATA_W-1:0]  m_writedata,
  output logic               m_clken,
  input  logic [DATA_W-1:0]  m_readdata
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_addr;
  logic [BURST_W-1:0] r_cnt;
  logic [BURST_W-1:0] w_bc_eff;
  logic [ADDR_W-1:0]  w_mask_new;
  logic [ADDR_W-1:0]  w_mask_cur;
  logic               w_wait;
  logic               w_beat_go;
  logic               w_beat_wr;
  logic [ADDR_W-1:0]  w_beat_addr;
  logic               w_in_range;

  logic [ADDR_W-1:0]  r_m_address;
  logic [BE_W-1:0]    r_m_be;
  logic               r_m_cs;
  logic               r_m_write;
  logic [DATA_W-1:0]  r_m_wdata;
  logic               r_m_clken;
  logic               r_rd_issue;
  logic               r_rd_oor;
  logic               r_beat_oor;
  logic               r_err;

  assign w_bc_eff   = (s_burstcount == '0) ? BURST_W'(1) : s_burstcount;
  assign w_in_range = 32'(w_beat_addr) < MEM_WORDS;

`ifdef ONCHIP_BURST_WRAP_EN
  logic [ADDR_W-1:0] r_mask;

  assign w_mask_new = window_mask(w_bc_eff);
  assign w_mask_cur = r_mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask <= '0;
    end else if (r_state == IDLE && w_beat_go) begin
      r_mask <= w_mask_new;
    end
  end
`else
  assign w_mask_new = '1;
  assign w_mask_cur = '1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // RD stays one extra cycle after the last issue so occupancy equals burstcount.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (s_write) begin
          w_state_nxt = (w_bc_eff != BURST_W'(1)) ? WR : IDLE;
        end else if (s_read) begin
          w_state_nxt = RD;
        end
      end
      RD: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end
      end
      WR: begin
        if (s_write && r_cnt == BURST_W'(1)) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_wait      = 1'b0;
    w_beat_go   = 1'b0;
    w_beat_wr   = 1'b0;
    w_beat_addr = r_addr;
    case (r_state)
      IDLE: begin
        if (s_write) begin
          w_beat_go   = 1'b1;
          w_beat_wr   = 1'b1;
          w_beat_addr = s_address;
        end else if (s_read) begin
          w_beat_go   = 1'b1;
          w_beat_addr = s_address;
        end
      end
      RD: begin
        w_wait    = 1'b1;
        w_beat_go = (r_cnt != '0);
      end
      WR: begin
        w_beat_go = s_write;
        w_beat_wr = s_write;
      end
      default: w_wait = 1'b0;
    endcase
  end

  assign s_waitrequest = reset | w_wait;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
      r_cnt  <= '0;
    end else if (w_beat_go) begin
      if (r_state == IDLE) begin
        r_cnt  <= w_bc_eff - 1'b1;
        r_addr <= next_addr(s_address, w_mask_new);
      end else begin
        r_cnt  <= r_cnt - 1'b1;
        r_addr <= next_addr(r_addr, w_mask_cur);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m_address <= '0;
      r_m_be      <= '0;
      r_m_cs      <= 1'b0;
      r_m_write   <= 1'b0;
      r_m_wdata   <= '0;
      r_m_clken   <= 1'b0;
      r_rd_issue  <= 1'b0;
      r_rd_oor    <= 1'b0;
      r_beat_oor  <= 1'b0;
    end else begin
      r_m_clken  <= 1'b1;
      r_m_cs     <= w_beat_go & w_in_range;
      r_m_write  <= w_beat_go & w_beat_wr;
      r_rd_issue <= w_beat_go & ~w_beat_wr;
      r_rd_oor   <= w_beat_go & ~w_beat_wr & ~w_in_range;
      r_beat_oor <= w_beat_go & ~w_in_range;
      if (w_beat_go) begin
        r_m_address <= w_beat_addr;
        r_m_be      <= w_beat_wr ? s_byteenable : '1;
        r_m_wdata   <= w_beat_wr ? s_writedata : '0;
      end
    end
  end

  // A new error outranks a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_beat_oor | (r_err & ~err_clr);
    end
  end

  onchip_mem_rd_return #(
    .DATA_W (DATA_W)
  ) u_rd_return (
    .clk      (clk),
    .rst      (reset),
    .i_issue  (r_rd_issue),
    .i_oor    (r_rd_oor),
    .i_rdata  (m_readdata),
    .o_rdata  (s_readdata),
    .o_rvalid (s_readdatavalid)
  );

  assign err_sticky   = r_err;
  assign m_address    = r_m_address;
  assign m_byteenable = r_m_be;
  assign m_chipselect = r_m_cs;
  assign m_write      = r_m_write;
  assign m_writedata  = r_m_wdata;
  assign m_clken      = r_m_clken;

endmodule

// File: tb/tb_onchip_mem_burst_adapter.sv
// tb/tb_onchip_mem_burst_adapter.sv - scoreboard bench for onchip_mem_burst_adapter with a RAM model
// Expectations follow ONCHIP_BURST_WRAP_EN when it is defined.
module tb_onchip_mem_burst_adapter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] s_address = '0;
  logic [3:0]  s_burstcount = '0;
  logic        s_read = 1'b0;
  logic        s_write = 1'b0;
  logic [31:0] s_writedata = '0;
  logic [3:0]  s_byteenable = '0;
  logic        s_waitrequest;
  logic [31:0] s_readdata;
  logic        s_readdatavalid;
  logic        err_sticky;
  logic        err_clr = 1'b0;
  logic [13:0] m_address;
  logic [3:0]  m_byteenable;
  logic        m_chipselect;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_clken;
  logic [31:0] m_readdata;

  onchip_mem_burst_adapter dut (
    .clk             (clk),
    .reset           (reset),
    .s_address       (s_address),
    .s_burstcount    (s_burstcount),
    .s_read          (s_read),
    .s_write         (s_write),
    .s_writedata     (s_writedata),
    .s_byteenable    (s_byteenable),
    .s_waitrequest   (s_waitrequest),
    .s_readdata      (s_readdata),
    .s_readdatavalid (s_readdatavalid),
    .err_sticky      (err_sticky),
    .err_clr         (err_clr),
    .m_address       (m_address),
    .m_byteenable    (m_byteenable),
    .m_chipselect    (m_chipselect),
    .m_write         (m_write),
    .m_writedata     (m_writedata),
    .m_clken         (m_clken),
    .m_readdata      (m_readdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [0:10239];
  always @(posedge clk) begin
    if (reset) begin
      mem[0]     <= 32'h0BAD_F00D;
      mem[16]    <= 32'hA5A5_0001;
      for (int i = 4; i < 10; i++) mem[i] <= 32'hD000_0000 + i;
      mem[10236] <= 32'h5555_6666;
      mem[10238] <= 32'h1111_2222;
      mem[10239] <= 32'h3333_4444;
    end else if (m_clken && m_chipselect && m_address < 14'd10240) begin
      if (m_write) begin
        for (int b = 0; b < 4; b++)
          if (m_byteenable[b]) mem[m_address][8*b +: 8] <= m_writedata[8*b +: 8];
      end else begin
        m_readdata <= mem[m_address];
      end
    end
  end

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rexp_q[$];
  logic [31:0] wdat_q[$];
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (s_readdatavalid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_readdatavalid: got data %h expected no beat", s_readdata);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", s_readdata, e.data);
          chk("rd_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (s_waitrequest !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("idle_timeout", 32'(s_waitrequest), 32'd0);
  endtask

  task automatic rd(input logic [13:0] a, input logic [3:0] bc, input int exp_wait);
    int n;
    int acc;
    @(negedge clk);
    wait_idle();
    s_address = a;
    s_burstcount = bc;
    s_read = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    for (int i = 0; i < rexp_q.size(); i++) exp_q.push_back('{rexp_q[i], acc + 2 + i});
    rexp_q.delete();
    @(negedge clk);
    s_read = 1'b0;
    n = 0;
    while (s_waitrequest === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("rd_wait_cycles", 32'(n), 32'(exp_wait));
  endtask

  // Later beats drive a bogus address and s_read=1 to show both are ignored in WR.
  task automatic wr(input logic [13:0] a, input logic [3:0] bc, input logic [3:0] be,
                    input int gap_at, input logic with_read);
    @(negedge clk);
    wait_idle();
    for (int i = 0; i < wdat_q.size(); i++) begin
      if (i > 0) begin
        @(negedge clk);
        if (i == gap_at) begin
          s_write = 1'b0;
          @(negedge clk);
        end
      end
      s_write = 1'b1;
      s_writedata = wdat_q[i];
      s_byteenable = be;
      s_address = (i == 0) ? a : 14'h3FFF;
      s_burstcount = bc;
      s_read = (i == 0) ? with_read : 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    s_write = 1'b0;
    s_read = 1'b0;
    wdat_q.delete();
  endtask

  initial begin : stim
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_waitrequest", 32'(s_waitrequest), 32'd1);
    chk("rst_rdvalid", 32'(s_readdatavalid), 32'd0);
    chk("rst_clken", 32'(m_clken), 32'd0);
    chk("rst_err", 32'(err_sticky), 32'd0);
    chk("rst_chipselect", 32'(m_chipselect), 32'd0);
    chk("rst_write", 32'(m_write), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_waitrequest", 32'(s_waitrequest), 32'd0);
    chk("run_clken", 32'(m_clken), 32'd1);

    rexp_q.push_back(32'hA5A5_0001);
    rd(14'h0010, 4'd1, 1);
    rexp_q.push_back(32'hA5A5_0001);
    rd(14'h0010, 4'd0, 1);

    wdat_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    wr(14'h0100, 4'd4, 4'hF, 2, 1'b0);
    rexp_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    rd(14'h0100, 4'd4, 4);

    wdat_q = '{32'h0};
    wr(14'h0200, 4'd1, 4'hF, -1, 1'b0);
    wdat_q = '{32'hFFFF_FFFF};
    wr(14'h0200, 4'd1, 4'h5, -1, 1'b0);
    rexp_q = '{32'h00FF_00FF};
    rd(14'h0200, 4'd1, 1);

    wdat_q = '{32'hCAFE_0001};
    wr(14'h0300, 4'd1, 4'hF, -1, 1'b1);
    chk("write_wins_idle", 32'(s_waitrequest), 32'd0);
    rexp_q = '{32'hCAFE_0001};
    rd(14'h0300, 4'd1, 1);

`ifdef ONCHIP_BURST_WRAP_EN
    rexp_q = '{32'hD000_0006, 32'hD000_0007, 32'hD000_0004, 32'hD000_0005};
`else
    rexp_q = '{32'hD000_0006, 32'hD000_0007, 32'hD000_0008, 32'hD000_0009};
`endif
    rd(14'h0006, 4'd4, 4);

    chk("err_clear_before", 32'(err_sticky), 32'd0);
`ifdef ONCHIP_BURST_WRAP_EN
    rexp_q = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
`else
    rexp_q = '{32'h1111_2222, 32'h3333_4444, 32'h0};
`endif
    rd(14'd10238, 4'd3, 3);
    repeat (3) @(negedge clk);
`ifdef ONCHIP_BURST_WRAP_EN
    chk("err_after_top_burst", 32'(err_sticky), 32'd0);
`else
    chk("err_after_top_burst", 32'(err_sticky), 32'd1);
`endif
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_cleared", 32'(err_sticky), 32'd0);

    err_clr = 1'b1;
    rexp_q = '{32'h0};
    rd(14'd10240, 4'd1, 1);
    chk("err_set_wins", 32'(err_sticky), 32'd1);
    @(negedge clk);
    chk("err_clr_after_set", 32'(err_sticky), 32'd0);
    err_clr = 1'b0;

`ifdef ONCHIP_BURST_WRAP_EN
    rexp_q = '{32'h0, 32'h0};
`else
    rexp_q = '{32'h0, 32'h0BAD_F00D};
`endif
    rd(14'h3FFF, 4'd2, 2);
    repeat (3) @(negedge clk);
    chk("err_addr_rollover", 32'(err_sticky), 32'd1);

    wait_idle();
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("pre_reset_drain", 32'(exp_q.size()), 32'd0);
    s_address = 14'h0100;
    s_burstcount = 4'd8;
    s_read = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_read = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midburst_rst_waitrequest", 32'(s_waitrequest), 32'd1);
    chk("midburst_rst_clken", 32'(m_clken), 32'd0);
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (s_readdatavalid !== 1'b0) n++;
    end
    reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (s_readdatavalid !== 1'b0) n++;
    end
    chk("midburst_no_rdvalid", 32'(n), 32'd0);
    chk("post_reset_idle", 32'(s_waitrequest), 32'd0);
    chk("post_reset_err", 32'(err_sticky), 32'd0);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
